pkt_chain_reader: RTL
=====================

# pkt_chain_reader

Parametrised single-channel packet reader for the switch egress path, successor to the fixed four-port reader. It accepts a packet descriptor (first block address, block count, last-block word count, drop flag) and walks the packet's linked list of buffer blocks. For each block it issues one next-pointer lookup, reads the block's words from the MMU, and streams them to the WRR scheduler with backpressure, using a credit-limited output FIFO. It recycles every freed block address. Dropped packets are unlinked and recycled without any MMU reads; the top level instantiates one copy per output port.

## Interface
- ADDR_LENTH, 12, block address width
- DATA_WIDTH, 32, data word width
- BLOCK_WORDS, 16, words per block; power of 2, ≥2
- BLKNUM_W, 4, width of block-count field
- OUT_DEPTH, 4, output FIFO depth; power of 2, ≥2
- iClk  in  1  clock
- iRst  in  1  reset; one clock; reset is asynchronous and active-high
- iPkgFirAddr  in  ADDR_LENTH  first block address
- iPkgBlockNum  in  BLKNUM_W  total blocks minus 1
- iPkgLastWords  in  log2(BLOCK_WORDS)  words in last block; 0 = full block
- iPkgDrop  in  1  discard packet
- iPkgVld / oPkgRdy  in/out  1  descriptor handshake
- oLaddr / oLaddrVld  out  ADDR_LENTH / 1  next-pointer lookup, 1-cycle pulse
- iLdata / iLdataVld  in  ADDR_LENTH / 1  next-pointer response, latency ≥1 cycle
- oMmuAddr  out  ADDR_LENTH+log2(BLOCK_WORDS)  {block, word}
- oMmuReadReq / iMmuRdy  out/in  1  word-read handshake
- oMmuReadLast  out  1  current request is the packet's final word
- iMmuData  in  DATA_WIDTH  read data, valid exactly 1 cycle after an accepted request
- oWrrData / oWrrVld / oWrrDataLast / iWrrRdy  out/out/out/in  DATA_WIDTH/1/1/1  output stream
- oRcvrAddr / oRcvrAddrVld  out  ADDR_LENTH / 1  freed block, 1-cycle pulse, no backpressure

## Operation
- States: IDLE, READ, WAIT_PTR, DROP, DROP_WAIT.
- IDLE
  - oPkgRdy=1.
  - On iPkgVld, latch cur_blk=iPkgFirAddr, blk_left=iPkgBlockNum, word=0, lastw=iPkgLastWords.
  - Go to DROP if iPkgDrop, else READ.
- Lookup at block entry: on entry to each block with blk_left≠0, pulse oLaddrVld with oLaddr=cur_blk. Exactly one lookup is outstanding at a time. The response is held in nxt_blk until it is used. iLdataVld with no outstanding lookup is ignored.
- READ
  - Issue oMmuReadReq only when the FIFO has room: fifo_count + inflight < OUT_DEPTH.
  - The word advances on iMmuRdy&oMmuReadReq.
  - Block word limit: BLOCK_WORDS, or lastw (if nonzero) when blk_left==0.
  - When the block's final word is accepted:
    - pulse recycle of cur_blk;
    - if blk_left==0, go to IDLE;
    - else if nxt_blk is valid, load it, decrement blk_left, word=0, stay in READ;
    - else go to WAIT_PTR.
- WAIT_PTR: on iLdataVld, load the block and return to READ.
- DROP: recycle cur_blk.
  - If blk_left==0, go to IDLE.
  - Else if the pointer is already held, advance in the same cycle.
  - Else go to DROP_WAIT; on iLdataVld, advance and re-enter DROP.
  - No MMU or WRR activity.
- Output FIFO
  - Written from iMmuData one cycle after each accepted read; carries a last flag.
  - oWrrVld = not empty; pop on oWrrVld&iWrrRdy.
  - oWrrDataLast marks the packet's final word.

## Timing
- All outputs reset to 0. State resets to IDLE; FIFO, counters and the pointer-valid flag are cleared.
- Descriptor-to-first-oMmuReadReq: 1 cycle. The lookup pulse coincides with the first read request.
- Read-to-FIFO latency: 1 cycle. With full FIFO bypass disabled, first oWrrVld comes 2 cycles after the first accepted read.
- Sustained throughput: 1 word/cycle when iMmuRdy=iWrrRdy=1 and the pointer returns within BLOCK_WORDS cycles.
- Recycle pulse: same cycle as the last-word accept (READ), or the DROP cycle. Recycle order equals list order.
- The next descriptor can be accepted 1 cycle after the final word is accepted. The FIFO may still hold the old packet; packets stay ordered.
- Reset mid-packet: in-flight data is discarded and partially walked blocks are not recycled.

## Structure
- Shared package holds the FSM state encoding, the log2 widths (WORD_W, CNT_W = log2(OUT_DEPTH)+1) and the descriptor struct layout.
- One sub-module: chain_rd_fifo, a synchronous FIFO with DATA_WIDTH+1 bits × OUT_DEPTH, count output, and async active-high reset.

## Test plan
- BlockNum=0, LastWords=5, first addr 0x010, always-ready → 5 words out, last on word 5, no lookup, one recycle of 0x010.
- BlockNum=2, LastWords=0, list 0x020→0x021→0x022, lookup latency 3 → 48 words in order, two lookups, recycles 0x020, 0x021, 0x022 in order, no gaps.
- Same packet with lookup latency 20 → WAIT_PTR entered twice, output word count and order unchanged.
- iWrrRdy random 50%, iMmuRdy random → oWrrData sequence intact, FIFO never overflows (fifo_count+inflight ≤ OUT_DEPTH).
- Drop packet BlockNum=3, addr 0x100 → zero oMmuReadReq and oWrrVld, four recycles 0x100..0x103, oPkgRdy back afterwards.
- iRst asserted mid-block-2 → all outputs 0 asynchronously, next descriptor processed cleanly from word 0.

Source files
------------

// File: rtl/pkt_chain_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : pkt_chain_reader_pkg
// Shared FSM encoding, default widths and descriptor layout for the reader.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package pkt_chain_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_PTR  = 3'd2,
        ST_DROP      = 3'd3,
        ST_DROP_WAIT = 3'd4
    } state_e;

    localparam int unsigned DEF_ADDR_LENTH  = 12;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_BLOCK_WORDS = 16;
    localparam int unsigned DEF_BLKNUM_W    = 4;
    localparam int unsigned DEF_OUT_DEPTH   = 4;

    function automatic int unsigned calc_word_w(input int unsigned words);
        return $clog2(words);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int unsigned calc_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned WORD_W = calc_word_w(DEF_BLOCK_WORDS);
    localparam int unsigned CNT_W  = calc_cnt_w(DEF_OUT_DEPTH);

    typedef struct packed {
        logic [DEF_ADDR_LENTH-1:0] fir_addr;
        logic [DEF_BLKNUM_W-1:0]   block_num;
        logic [WORD_W-1:0]         last_words;
        logic                      drop;
    } pkt_desc_t;

endpackage
`default_nettype wire

// File: rtl/chain_rd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : chain_rd_fifo
// Small synchronous FIFO with occupancy count; read data is zero when empty.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module chain_rd_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign empty_o   = (count_q == '0);
    assign w_full    = (count_q == CNT_W'(DEPTH));
    assign w_pop     = rd_en_i && !empty_o;
    assign w_push    = wr_en_i && (!w_full || w_pop);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_chain_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pkt_chain_reader
// Walks a packet's linked block list, reads its words from the MMU into a
// credit-limited FIFO toward the WRR scheduler, and recycles freed blocks.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module pkt_chain_reader
    import pkt_chain_reader_pkg::*;
#(
    parameter int unsigned ADDR_LENTH  = DEF_ADDR_LENTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int unsigned BLKNUM_W    = DEF_BLKNUM_W,
    parameter int unsigned OUT_DEPTH   = DEF_OUT_DEPTH
) (
    input  logic                                      iClk,
    input  logic                                      iRst,
    input  logic [ADDR_LENTH-1:0]                     iPkgFirAddr,
    input  logic [BLKNUM_W-1:0]                       iPkgBlockNum,
    input  logic [$clog2(BLOCK_WORDS)-1:0]            iPkgLastWords,
    input  logic                                      iPkgDrop,
    input  logic                                      iPkgVld,
    output logic                                      oPkgRdy,
    output logic [ADDR_LENTH-1:0]                     oLaddr,
    output logic                                      oLaddrVld,
    input  logic [ADDR_LENTH-1:0]                     iLdata,
    input  logic                                      iLdataVld,
    output logic [ADDR_LENTH+$clog2(BLOCK_WORDS)-1:0] oMmuAddr,
    output logic                                      oMmuReadReq,
    input  logic                                      iMmuRdy,
    output logic                                      oMmuReadLast,
    input  logic [DATA_WIDTH-1:0]                     iMmuData,
    output logic [DATA_WIDTH-1:0]                     oWrrData,
    output logic                                      oWrrVld,
    output logic                                      oWrrDataLast,
    input  logic                                      iWrrRdy,
    output logic [ADDR_LENTH-1:0]                     oRcvrAddr,
    output logic                                      oRcvrAddrVld
);

    localparam int unsigned BLK_WORD_W = calc_word_w(BLOCK_WORDS);
    localparam int unsigned FIFO_CNT_W = calc_cnt_w(OUT_DEPTH);

    state_e                  state_q,     state_d;
    logic [ADDR_LENTH-1:0]   cur_blk_q,   cur_blk_d;
    logic [BLKNUM_W-1:0]     blk_left_q,  blk_left_d;
    logic [BLK_WORD_W-1:0]   word_q,      word_d;
    logic [BLK_WORD_W-1:0]   lastw_q,     lastw_d;
    logic [ADDR_LENTH-1:0]   nxt_blk_q,   nxt_blk_d;
    logic                    nxt_vld_q,   nxt_vld_d;
    logic                    lk_pend_q,   lk_pend_d;
    logic                    lk_done_q,   lk_done_d;
    logic                    infl_q,      infl_d;
    logic                    infl_last_q, infl_last_d;
    logic                    live_q;

    logic [FIFO_CNT_W-1:0]   w_fifo_cnt;
    logic                    w_fifo_empty;
    logic [DATA_WIDTH:0]     w_fifo_rd;
    logic [FIFO_CNT_W:0]     w_occ;
    logic                    w_room;
    logic                    w_ptr_vld;
    logic [ADDR_LENTH-1:0]   w_ptr;
    logic                    w_lk;
    logic                    w_req;
    logic                    w_acc;
    logic                    w_blk_end;
    logic                    w_rcv;
    logic                    w_adv;

    // A read may only launch if its word is guaranteed a FIFO slot.
    assign w_occ  = {1'b0, w_fifo_cnt} + {{FIFO_CNT_W{1'b0}}, infl_q};
    assign w_room = (w_occ < (FIFO_CNT_W + 1)'(OUT_DEPTH));

    // A response arriving this cycle counts as held, so block hand-off never stalls.
    assign w_ptr_vld = nxt_vld_q || (lk_pend_q && iLdataVld);
    assign w_ptr     = nxt_vld_q ? nxt_blk_q : iLdata;

    assign w_blk_end = ((blk_left_q == '0) && (lastw_q != '0)) ? (word_q == lastw_q - 1'b1)
                                                               : (word_q == '1);

    assign w_lk  = ((state_q == ST_READ) || (state_q == ST_DROP)) &&
                   (blk_left_q != '0) && !lk_done_q;
    assign w_req = (state_q == ST_READ) && w_room;
    assign w_acc = w_req && iMmuRdy;
    assign w_rcv = ((state_q == ST_READ) && w_acc && w_blk_end) || (state_q == ST_DROP);

    assign oPkgRdy      = live_q && (state_q == ST_IDLE);
    assign oLaddrVld    = w_lk;
    assign oLaddr       = w_lk ? cur_blk_q : '0;
    assign oMmuReadReq  = w_req;
    assign oMmuAddr     = {cur_blk_q, word_q};
    assign oMmuReadLast = w_req && (blk_left_q == '0) && w_blk_end;
    assign oRcvrAddrVld = w_rcv;
    assign oRcvrAddr    = w_rcv ? cur_blk_q : '0;
    assign oWrrVld      = !w_fifo_empty;
    assign oWrrData     = w_fifo_rd[DATA_WIDTH-1:0];
    assign oWrrDataLast = w_fifo_rd[DATA_WIDTH];

    chain_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (OUT_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .wr_en_i   (infl_q),
        .wr_data_i ({infl_last_q, iMmuData}),
        .rd_en_i   (iWrrRdy),
        .rd_data_o (w_fifo_rd),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        cur_blk_d   = cur_blk_q;
        blk_left_d  = blk_left_q;
        word_d      = word_q;
        lastw_d     = lastw_q;
        nxt_blk_d   = nxt_blk_q;
        nxt_vld_d   = nxt_vld_q;
        lk_pend_d   = lk_pend_q;
        lk_done_d   = lk_done_q;
        infl_d      = w_acc;
        infl_last_d = w_acc && (blk_left_q == '0) && w_blk_end;
        w_adv       = 1'b0;

        if (lk_pend_q && iLdataVld) begin
            lk_pend_d = 1'b0;
            nxt_blk_d = iLdata;
            nxt_vld_d = 1'b1;
        end
        if (w_lk) begin
            lk_pend_d = 1'b1;
            lk_done_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iPkgVld && oPkgRdy) begin
                    cur_blk_d  = iPkgFirAddr;
                    blk_left_d = iPkgBlockNum;
                    word_d     = '0;
                    lastw_d    = iPkgLastWords;
                    nxt_vld_d  = 1'b0;
                    lk_done_d  = 1'b0;
                    state_d    = iPkgDrop ? ST_DROP : ST_READ;
                end
            end
            ST_READ: begin
                if (w_acc) begin
                    if (!w_blk_end) begin
                        word_d = word_q + 1'b1;
                    end else if (blk_left_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (w_ptr_vld) begin
                        w_adv = 1'b1;
                    end else begin
                        state_d = ST_WAIT_PTR;
                    end
                end
            end
            ST_WAIT_PTR: begin
                if (w_ptr_vld) begin
                    w_adv   = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_DROP: begin
                if (blk_left_q == '0) begin
                    state_d = ST_IDLE;
                end else if (w_ptr_vld) begin
                    w_adv = 1'b1;
                end else begin
                    state_d = ST_DROP_WAIT;
                end
            end
            ST_DROP_WAIT: begin
                if (w_ptr_vld) begin
                    w_adv   = 1'b1;
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_adv) begin
            cur_blk_d  = w_ptr;
            blk_left_d = blk_left_q - 1'b1;
            word_d     = '0;
            nxt_vld_d  = 1'b0;
            lk_done_d  = 1'b0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            cur_blk_q   <= '0;
            blk_left_q  <= '0;
            word_q      <= '0;
            lastw_q     <= '0;
            nxt_blk_q   <= '0;
            nxt_vld_q   <= 1'b0;
            lk_pend_q   <= 1'b0;
            lk_done_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_blk_q   <= cur_blk_d;
            blk_left_q  <= blk_left_d;
            word_q      <= word_d;
            lastw_q     <= lastw_d;
            nxt_blk_q   <= nxt_blk_d;
            nxt_vld_q   <= nxt_vld_d;
            lk_pend_q   <= lk_pend_d;
            lk_done_q   <= lk_done_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            live_q      <= 1'b1;
        end
    end

endmodule
`default_nettype wire
